seq_101_win_cnt: RTL and testbench

- Downstream consumer of the serial "101" detector: counts detector pulses over fixed windows of WIN_LEN serial bits.
- At each window close, it publishes the count through a one-entry valid/ready output register.
- Gives the host a per-window hit count instead of a raw single-cycle flag.
- Flags overrun when a result is lost to backpressure.

---
 rtl/seq_pkg.sv | 22 ++
 rtl/sat_cnt.sv | 24 ++
 rtl/seq_101_win_cnt.sv | 85 ++++++++
 tb/tb_seq_101_win_cnt.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared types and helpers for the "101" window counter.
//   state_t   - window FSM states (IDLE before the first bit, COUNT afterwards)
//   DEF_CNT_W - default width of the published hit count
//   clog2     - bit width needed to index v positions (minimum 1)
package seq_pkg;

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    localparam int DEF_CNT_W = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < v) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sat_cnt.sv
// sat_cnt: saturating up-counter with synchronous clear.
//   clk - clock
//   rst - synchronous active-low reset
//   clr - synchronous clear, dominates inc
//   inc - count up by one, holding at all-ones
//   q   - current count
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst || clr)
            q <= '0;
        else if (inc && q != '1)
            q <= q + W'(1);
    end

endmodule

// File: rtl/seq_101_win_cnt.sv
// seq_101_win_cnt: counts "101" detector hits over windows of WIN_LEN serial bits.
//   clk       - clock
//   rst       - synchronous active-low reset
//   bit_en    - a serial bit was consumed this cycle
//   flag_101  - detector hit, qualified by bit_en
//   out_cnt   - hit count of the last completed window
//   out_valid - out_cnt holds an unconsumed result
//   out_ready - consumer accepts out_cnt when out_valid && out_ready
//   overrun   - sticky: a completed window was dropped under backpressure
//   busy      - a window is in progress
module seq_101_win_cnt
    import seq_pkg::*;
#(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             flag_101,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             busy
);

    localparam int IW = clog2(WIN_LEN);

    state_t           state, next_state;
    logic [IW-1:0]    idx;
    logic [CNT_W-1:0] hit;
    logic [CNT_W-1:0] result;
    logic             close;

    assign close  = bit_en && idx == IW'(WIN_LEN - 1);
    // The closing bit's own flag is folded in here because the counter is cleared that cycle.
    assign result = (hit == '1) ? hit : hit + CNT_W'(flag_101);
    assign busy   = state == COUNT;

    sat_cnt #(.W(CNT_W)) u_hit (
        .clk (clk),
        .rst (rst),
        .clr (close),
        .inc (bit_en && flag_101),
        .q   (hit)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (state == IDLE && bit_en)
            next_state = COUNT;
    end

    always_ff @(posedge clk) begin
        if (!rst || close)
            idx <= '0;
        else if (bit_en)
            idx <= idx + IW'(1);
    end

    // A close may load over a result being transferred in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_cnt   <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (close) begin
            if (!out_valid || out_ready) begin
                out_cnt   <= result;
                out_valid <= 1'b1;
            end else
                overrun <= 1'b1;
        end else if (out_ready)
            out_valid <= 1'b0;
    end

endmodule

// File: tb/tb_seq_101_win_cnt.sv
module tb_seq_101_win_cnt;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bit_en = 1'b0;
    logic       flag_101 = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] out_cnt;
    logic       out_valid, overrun, busy;

    logic       b_rst = 1'b0;
    logic       b_en = 1'b0;
    logic       b_flag = 1'b0;
    logic       b_ready = 1'b1;
    logic [1:0] b_cnt;
    logic       b_valid, b_overrun, b_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_101_win_cnt #(.WIN_LEN(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_en    (bit_en),
        .flag_101  (flag_101),
        .out_cnt   (out_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .busy      (busy)
    );

    seq_101_win_cnt #(.WIN_LEN(16), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst       (b_rst),
        .bit_en    (b_en),
        .flag_101  (b_flag),
        .out_cnt   (b_cnt),
        .out_valid (b_valid),
        .out_ready (b_ready),
        .overrun   (b_overrun),
        .busy      (b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic be, input logic fl);
        bit_en   = be;
        flag_101 = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic btick(input logic be, input logic fl);
        b_en   = be;
        b_flag = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        rst = 1'b0;
        b_rst = 1'b0;
        tick(1, 1);
        tick(1, 1);
        check("rst_cnt", out_cnt, 0);
        check("rst_valid", out_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        b_rst = 1'b1;
        tick(0, 0);
        check("idle_busy", busy, 0);

        // test 1: 1010 1010, flags at bits 2,4,6
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1, i == 2 || i == 4 || i == 6);
            if (i == 0) check("t1_busy", busy, 1);
            if (i == 6) check("t1_valid_early", out_valid, 0);
        end
        check("t1_valid", out_valid, 1);
        check("t1_cnt", out_cnt, 3);
        check("t1_overrun", overrun, 0);

        // test 2: zero window with stalls carrying flags
        tick(1, 0);
        check("t2_xfer", out_valid, 0);
        check("t2_cnt_hold", out_cnt, 3);
        for (int i = 1; i < 4; i++) tick(1, 0);
        for (int i = 0; i < 3; i++) tick(0, 1);
        for (int i = 4; i < 7; i++) tick(1, 0);
        check("t2_delayed", out_valid, 0);
        tick(1, 0);
        check("t2_valid", out_valid, 1);
        check("t2_cnt", out_cnt, 0);

        // test 3: backpressure across two windows (3 hits, then 1 hit)
        tick(1, 0);
        out_ready = 1'b0;
        for (int i = 1; i < 8; i++) tick(1, i == 2 || i == 4 || i == 6);
        check("t3_cnt_a", out_cnt, 3);
        check("t3_valid_a", out_valid, 1);
        check("t3_ovr_a", overrun, 0);
        for (int i = 0; i < 8; i++) tick(1, i == 3);
        check("t3_cnt_b", out_cnt, 3);
        check("t3_valid_b", out_valid, 1);
        check("t3_ovr_b", overrun, 1);
        out_ready = 1'b1;
        tick(0, 0);
        check("t3_xfer", out_valid, 0);
        check("t3_ovr_sticky", overrun, 1);
        check("t3_cnt_keep", out_cnt, 3);

        // test 4: transfer coincides with close
        rst = 1'b0;
        tick(0, 0);
        rst = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) tick(1, i == 2 || i == 4 || i == 6);
        check("t4_cnt_a", out_cnt, 3);
        check("t4_ovr_clr", overrun, 0);
        for (int i = 0; i < 7; i++) tick(1, i == 2 || i == 4);
        out_ready = 1'b1;
        tick(1, 0);
        check("t4_cnt", out_cnt, 2);
        check("t4_valid", out_valid, 1);
        check("t4_ovr", overrun, 0);
        tick(0, 0);
        check("t4_drain", out_valid, 0);

        // test 6: reset mid-window with a pending result
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) tick(1, i == 5);
        check("t6_pending", out_valid, 1);
        for (int i = 0; i < 5; i++) tick(1, i == 2 || i == 4);
        rst = 1'b0;
        tick(1, 1);
        check("t6_valid", out_valid, 0);
        check("t6_cnt", out_cnt, 0);
        check("t6_ovr", overrun, 0);
        check("t6_busy", busy, 0);
        rst = 1'b1;
        out_ready = 1'b1;
        tick(0, 1);
        tick(0, 0);
        check("t6_idle", busy, 0);
        for (int i = 0; i < 8; i++) begin
            tick(1, i == 3);
            if (i == 6) check("t6_early", out_valid, 0);
        end
        check("t6_fresh_valid", out_valid, 1);
        check("t6_fresh_cnt", out_cnt, 1);

        // test 5: saturation with a 2-bit count over 16-bit windows
        b_ready = 1'b1;
        for (int i = 0; i < 16; i++) btick(1, i >= 2 && i % 2 == 0);
        check("t5_valid", b_valid, 1);
        check("t5_cnt", b_cnt, 3);
        for (int i = 0; i < 16; i++) begin
            btick(1, 1);
            if (i == 0) check("t5_xfer", b_valid, 0);
        end
        check("t5_sat_flag_close", b_cnt, 3);
        check("t5_valid2", b_valid, 1);
        check("t5_ovr", b_overrun, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
